// File: rtl/wb_pkg.sv
// Shared widths, source ids and the writeback entry payload for the regfile writeback arbiter.
package wb_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small per-source writeback FIFO; exposes head, empty/full and per-slot valid/rd for hazard queries.
// Entry layout assumes rd occupies the top RD_W bits of each word.
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 69,
    parameter int unsigned RD_W  = 5
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic                       full,
    output logic [DEPTH-1:0]           valid_vec,
    output logic [DEPTH-1:0][RD_W-1:0] rd_vec
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == CW'(0));
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (pop_ok && !push_ok) count <= count - CW'(1);
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        valid_vec = '0;
        rd_vec    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ({1'b0, PW'(i) - rd_ptr} < count);
            rd_vec[i]    = mem[i][W-1 -: RD_W];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register file write port between the ALU and load writeback sources.
// Optional macro WB_PENDING_QUERY_EN builds the rs1/rs2 pending comparators; otherwise pend_* are 0.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [REG_AW-1:0] s0_rd,
    input  logic [XLEN-1:0]   s0_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [REG_AW-1:0] s1_rd,
    input  logic [XLEN-1:0]   s1_data,
    output logic              regWrite,
    output logic [REG_AW-1:0] wr,
    output logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              pend_rs1,
    output logic              pend_rs2
);

    localparam int unsigned EW = $bits(wb_entry_t);

    wb_entry_t                   in0, in1, head0, head1, head;
    logic                        empty0, empty1, full0, full1;
    logic                        pop0, pop1;
    logic [DEPTH-1:0]            valid0, valid1;
    logic [DEPTH-1:0][REG_AW-1:0] rdv0, rdv1;
    logic                        gnt_valid;
    logic                        gnt_src;
    logic                        rr_last;

    assign in0 = '{rd: s0_rd, data: s0_data};
    assign in1 = '{rd: s1_rd, data: s1_data};

    assign s0_ready = !full0;
    assign s1_ready = !full1;

    wb_fifo #(.DEPTH(DEPTH), .W(EW), .RD_W(REG_AW)) u_fifo0 (
        .clock(clock), .reset_n(reset_n), .push(s0_valid), .pop(pop0), .din(in0),
        .head(head0), .empty(empty0), .full(full0), .valid_vec(valid0), .rd_vec(rdv0)
    );

    wb_fifo #(.DEPTH(DEPTH), .W(EW), .RD_W(REG_AW)) u_fifo1 (
        .clock(clock), .reset_n(reset_n), .push(s1_valid), .pop(pop1), .din(in1),
        .head(head1), .empty(empty1), .full(full1), .valid_vec(valid1), .rd_vec(rdv1)
    );

    // Grant: lone non-empty source wins; on contention the source that did not win last time.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_src   = SRC_ALU;
        if (!empty0 && !empty1) begin
            gnt_valid = 1'b1;
            gnt_src   = (rr_last == SRC_ALU) ? SRC_MEM : SRC_ALU;
        end else if (!empty0) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_ALU;
        end else if (!empty1) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_MEM;
        end
    end

    assign pop0 = gnt_valid && (gnt_src == SRC_ALU);
    assign pop1 = gnt_valid && (gnt_src == SRC_MEM);

    // Write port mux; an x0 entry is consumed without asserting the write enable.
    always_comb begin
        head     = (gnt_src == SRC_MEM) ? head1 : head0;
        regWrite = gnt_valid && (head.rd != '0);
        wr       = regWrite ? head.rd : '0;
        wdata    = regWrite ? head.data : '0;
    end

    // Round-robin history; reset to the load source so the ALU wins the first tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       rr_last <= SRC_MEM;
        else if (gnt_valid) rr_last <= gnt_src;
    end

`ifdef WB_PENDING_QUERY_EN
    // Pending query: any live slot in either FIFO targeting a nonzero rs, head included.
    always_comb begin
        pend_rs1 = 1'b0;
        pend_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid0[i] && rdv0[i] == rs1) pend_rs1 = 1'b1;
            if (valid1[i] && rdv1[i] == rs1) pend_rs1 = 1'b1;
            if (valid0[i] && rdv0[i] == rs2) pend_rs2 = 1'b1;
            if (valid1[i] && rdv1[i] == rs2) pend_rs2 = 1'b1;
        end
        if (rs1 == '0) pend_rs1 = 1'b0;
        if (rs2 == '0) pend_rs2 = 1'b0;
    end
`else
    logic unused_pend;
    assign unused_pend = ^{valid0, valid1, rdv0, rdv1, rs1, rs2};
    assign pend_rs1    = 1'b0;
    assign pend_rs2    = 1'b0;
`endif

endmodule
